// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: TX/RX byte FIFOs between the bus-side UART registers and UART_core.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   tx_en             core transmitter enabled; no byte is launched while low
//   tx_push/tx_wdata  enqueue one byte for transmission
//   tx_flush          drop all queued TX bytes
//   tx_full/tx_count  TX FIFO status (registered-state derived)
//   rx_pop            discard RX head; rx_rdata shows the head (first-word-fall-through)
//   rx_flush          drop all buffered RX bytes
//   rx_rdata/rx_empty/rx_count  RX FIFO status (registered-state derived)
//   clr_err           clear sticky tx_overflow / rx_overrun
//   core_we/core_di   byte launch into the core (reg_dat_we/reg_dat_di)
//   core_tx_empty     core transmit buffer empty (tx_buf_empty)
//   core_re           combinational read strobe to the core (reg_dat_re)
//   core_do/core_rx_valid  received byte from the core (reg_dat_do/rx_buf_valid)
module uart_fifo_bridge #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  tx_push,
    input  logic [7:0]            tx_wdata,
    input  logic                  tx_flush,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_count,
    input  logic                  rx_pop,
    input  logic                  rx_flush,
    output logic [7:0]            rx_rdata,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_count,
    input  logic                  clr_err,
    output logic                  tx_overflow,
    output logic                  rx_overrun,
    output logic                  core_we,
    output logic [7:0]            core_di,
    input  logic                  core_tx_empty,
    output logic                  core_re,
    input  logic [7:0]            core_do,
    input  logic                  core_rx_valid
);

    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_GUARD} tx_state_t;
    typedef enum logic       {R_IDLE, R_GUARD}          rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wptr, tx_rptr;
    logic [CW-1:0] tx_cnt;
    logic          tx_full_int;
    logic          tx_wr, tx_rd, tx_ovf_set;

    tx_state_t tx_state, tx_next;
    logic      tx_launch;

    assign tx_full_int = (tx_cnt == CW'(DEPTH));
    assign tx_full     = tx_full_int;
    assign tx_count    = tx_cnt;

    // Full is judged before the edge, so a same-cycle launch never makes room.
    assign tx_wr      = tx_push & ~tx_full_int & ~tx_flush;
    assign tx_ovf_set = tx_push &  tx_full_int & ~tx_flush;
    assign tx_rd      = tx_launch;

    // TX storage (no reset needed; validity tracked by pointers)
    always_ff @(posedge clk) begin
        if (tx_wr) begin
            tx_mem[tx_wptr] <= tx_wdata;
        end
    end

    // TX pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_wr) tx_wptr <= tx_wptr + PW'(1);
            if (tx_rd) tx_rptr <= tx_rptr + PW'(1);
            case ({tx_wr, tx_rd})
                2'b10:   tx_cnt <= tx_cnt + CW'(1);
                2'b01:   tx_cnt <= tx_cnt - CW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // TX FSM next state: launch, one-cycle strobe, then one cycle ignoring a stale tx_buf_empty
    always_comb begin
        tx_next   = tx_state;
        tx_launch = 1'b0;
        unique case (tx_state)
            T_IDLE: begin
                if (tx_en && core_tx_empty && (tx_cnt != '0)) begin
                    tx_launch = 1'b1;
                    tx_next   = T_ISSUE;
                end
            end
            T_ISSUE: tx_next = T_GUARD;
            T_GUARD: tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    // TX FSM state and registered core strobe/data
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            core_we  <= 1'b0;
            core_di  <= '0;
        end else begin
            tx_state <= tx_next;
            core_we  <= (tx_next == T_ISSUE);
            if (tx_launch) core_di <= tx_mem[tx_rptr];
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wptr, rx_rptr;
    logic [CW-1:0] rx_cnt;
    logic          rx_full_int, rx_empty_int;
    logic          rx_wr, rx_rd, rx_ovr_set;

    rx_state_t rx_state, rx_next;

    assign rx_full_int  = (rx_cnt == CW'(DEPTH));
    assign rx_empty_int = (rx_cnt == '0);
    assign rx_empty     = rx_empty_int;
    assign rx_count     = rx_cnt;
    assign rx_rdata     = rx_mem[rx_rptr];

    // A pop while full frees no space this cycle, so the core byte is dropped.
    assign rx_wr      = core_re & ~rx_full_int & ~rx_flush;
    assign rx_ovr_set = core_re &  rx_full_int & ~rx_flush;
    assign rx_rd      = rx_pop  & ~rx_empty_int & ~rx_flush;

    // RX FSM: acknowledge a valid byte, then skip one cycle while the core clears rx_buf_valid
    always_comb begin
        rx_next = rx_state;
        core_re = 1'b0;
        unique case (rx_state)
            R_IDLE: begin
                if (core_rx_valid) begin
                    core_re = 1'b1;
                    rx_next = R_GUARD;
                end
            end
            R_GUARD: rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // RX FSM state register
    always_ff @(posedge clk) begin
        if (rst) rx_state <= R_IDLE;
        else     rx_state <= rx_next;
    end

    // RX storage
    always_ff @(posedge clk) begin
        if (rx_wr) begin
            rx_mem[rx_wptr] <= core_do;
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_wr) rx_wptr <= rx_wptr + PW'(1);
            if (rx_rd) rx_rptr <= rx_rptr + PW'(1);
            case ({rx_wr, rx_rd})
                2'b10:   rx_cnt <= rx_cnt + CW'(1);
                2'b01:   rx_cnt <= rx_cnt - CW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Sticky error flags; a new event outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            if (tx_ovf_set)   tx_overflow <= 1'b1;
            else if (clr_err) tx_overflow <= 1'b0;
            if (rx_ovr_set)   rx_overrun  <= 1'b1;
            else if (clr_err) rx_overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed self-checking bench for uart_fifo_bridge (DEPTH_LOG2 = 4).
module tb_uart_fifo_bridge;

    localparam int unsigned DL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_en;
    logic          tx_push;
    logic [7:0]    tx_wdata;
    logic          tx_flush;
    logic          tx_full;
    logic [DL:0]   tx_count;
    logic          rx_pop;
    logic          rx_flush;
    logic [7:0]    rx_rdata;
    logic          rx_empty;
    logic [DL:0]   rx_count;
    logic          clr_err;
    logic          tx_overflow;
    logic          rx_overrun;
    logic          core_we;
    logic [7:0]    core_di;
    logic          core_tx_empty;
    logic          core_re;
    logic [7:0]    core_do;
    logic          core_rx_valid;

    int n_checks = 0;
    int n_fail   = 0;

    uart_fifo_bridge #(.DEPTH_LOG2(DL)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_en         (tx_en),
        .tx_push       (tx_push),
        .tx_wdata      (tx_wdata),
        .tx_flush      (tx_flush),
        .tx_full       (tx_full),
        .tx_count      (tx_count),
        .rx_pop        (rx_pop),
        .rx_flush      (rx_flush),
        .rx_rdata      (rx_rdata),
        .rx_empty      (rx_empty),
        .rx_count      (rx_count),
        .clr_err       (clr_err),
        .tx_overflow   (tx_overflow),
        .rx_overrun    (rx_overrun),
        .core_we       (core_we),
        .core_di       (core_di),
        .core_tx_empty (core_tx_empty),
        .core_re       (core_re),
        .core_do       (core_do),
        .core_rx_valid (core_rx_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_q [$];

    initial begin
        rst = 1'b1; tx_en = 1'b1; tx_push = 1'b0; tx_wdata = '0; tx_flush = 1'b0;
        rx_pop = 1'b0; rx_flush = 1'b0; clr_err = 1'b0; core_tx_empty = 1'b1;
        core_do = '0; core_rx_valid = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_tx_count", 32'(tx_count), 0);
        check("rst_tx_full",  32'(tx_full), 0);
        check("rst_rx_empty", 32'(rx_empty), 1);
        check("rst_rx_count", 32'(rx_count), 0);
        check("rst_core_we",  32'(core_we), 0);
        check("rst_core_di",  32'(core_di), 0);
        check("rst_core_re",  32'(core_re), 0);
        check("rst_flags",    32'({tx_overflow, rx_overrun}), 0);

        // Back-to-back pushes 0x55, 0xA3 with the core idle
        tx_push = 1'b1; tx_wdata = 8'h55;
        step();
        check("t1_cnt_a", 32'(tx_count), 1);
        check("t1_we_a",  32'(core_we), 0);
        tx_wdata = 8'hA3;
        step();                                   // 0x55 launched, 0xA3 stored
        check("t1_we_b",  32'(core_we), 1);
        check("t1_di_b",  32'(core_di), 32'h55);
        check("t1_cnt_b", 32'(tx_count), 1);
        tx_push = 1'b0; core_tx_empty = 1'b0;     // core starts its frame
        step();
        check("t1_we_c",  32'(core_we), 0);
        check("t1_di_c",  32'(core_di), 32'h55);
        step(); step();
        check("t1_we_busy",  32'(core_we), 0);
        check("t1_cnt_busy", 32'(tx_count), 1);
        core_tx_empty = 1'b1;                     // frame done
        step();
        check("t1_we_d",  32'(core_we), 1);
        check("t1_di_d",  32'(core_di), 32'hA3);
        check("t1_cnt_d", 32'(tx_count), 0);
        step();
        check("t1_we_e",  32'(core_we), 0);
        step(); step();

        // TX overflow with the transmitter disabled
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tx_push = 1'b1; tx_wdata = 8'(i);
            step();
        end
        check("t2_full",  32'(tx_full), 1);
        check("t2_cnt",   32'(tx_count), 16);
        check("t2_ovf0",  32'(tx_overflow), 0);
        tx_wdata = 8'hEE;
        step();
        check("t2_ovf1",  32'(tx_overflow), 1);
        check("t2_cnt17", 32'(tx_count), 16);
        check("t2_we",    32'(core_we), 0);
        tx_push = 1'b0; clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t2_clr",   32'(tx_overflow), 0);
        tx_flush = 1'b1; tx_push = 1'b1;          // flush beats a push on a full FIFO
        step();
        tx_flush = 1'b0; tx_push = 1'b0;
        check("t2_fl_cnt",  32'(tx_count), 0);
        check("t2_fl_full", 32'(tx_full), 0);
        check("t2_fl_ovf",  32'(tx_overflow), 0);

        // Single RX byte
        core_rx_valid = 1'b1; core_do = 8'h3C;
        #1;
        check("t3_re",    32'(core_re), 1);
        step();
        core_rx_valid = 1'b0;
        check("t3_empty", 32'(rx_empty), 0);
        check("t3_data",  32'(rx_rdata), 32'h3C);
        check("t3_cnt",   32'(rx_count), 1);
        check("t3_re0",   32'(core_re), 0);
        rx_pop = 1'b1;
        step();
        rx_pop = 1'b0;
        check("t3_pop_empty", 32'(rx_empty), 1);
        check("t3_pop_cnt",   32'(rx_count), 0);
        rx_pop = 1'b1;                            // pop on empty is ignored
        step();
        rx_pop = 1'b0;
        check("t3_pop_none",  32'(rx_count), 0);

        // Fill RX, then overrun with a same-cycle clr_err
        for (int i = 0; i < 16; i++) begin
            core_rx_valid = 1'b1; core_do = 8'(8'h10 + i);
            step();
            core_rx_valid = 1'b0;
            step();
        end
        check("t4_cnt",  32'(rx_count), 16);
        check("t4_head", 32'(rx_rdata), 32'h10);
        core_rx_valid = 1'b1; core_do = 8'h99; clr_err = 1'b1;
        #1;
        check("t4_re",   32'(core_re), 1);
        step();
        core_rx_valid = 1'b0; clr_err = 1'b0;
        check("t4_ovr",     32'(rx_overrun), 1);
        check("t4_cnt_ovr", 32'(rx_count), 16);
        check("t4_head2",   32'(rx_rdata), 32'h10);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t4_clr",  32'(rx_overrun), 0);
        for (int i = 0; i < 11; i++) begin
            check("t4_order", 32'(rx_rdata), 32'(8'h10 + i));
            rx_pop = 1'b1;
            step();
            rx_pop = 1'b0;
        end
        check("t4_cnt5", 32'(rx_count), 5);

        // Simultaneous pop and core write at count 5
        rx_pop = 1'b1; core_rx_valid = 1'b1; core_do = 8'h77;
        step();
        rx_pop = 1'b0; core_rx_valid = 1'b0;
        check("t5_cnt",  32'(rx_count), 5);
        exp_q = '{8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h77};
        foreach (exp_q[i]) begin
            check("t5_order", 32'(rx_rdata), 32'(exp_q[i]));
            rx_pop = 1'b1;
            step();
            rx_pop = 1'b0;
        end
        check("t5_empty", 32'(rx_empty), 1);

        // Reset while a byte is in T_ISSUE with data queued in both FIFOs
        for (int i = 0; i < 17; i++) begin
            tx_push = 1'b1; tx_wdata = 8'(8'h40 + i);
            step();
        end
        tx_push = 1'b0;
        core_rx_valid = 1'b1; core_do = 8'h42;
        step();
        core_rx_valid = 1'b0;
        check("t6_pre_ovf",   32'(tx_overflow), 1);
        check("t6_pre_rx",    32'(rx_count), 1);
        tx_en = 1'b1;
        step();
        check("t6_issue_we",  32'(core_we), 1);
        check("t6_issue_di",  32'(core_di), 32'h40);
        check("t6_issue_cnt", 32'(tx_count), 15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_we",       32'(core_we), 0);
        check("t6_tx_cnt",   32'(tx_count), 0);
        check("t6_tx_full",  32'(tx_full), 0);
        check("t6_rx_empty", 32'(rx_empty), 1);
        check("t6_ovf",      32'(tx_overflow), 0);
        check("t6_di",       32'(core_di), 0);
        tx_en = 1'b0;
        step();
        check("t6_idle_we",  32'(core_we), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
